// File: rtl/sim_cfg_pkg.sv
// Shared simulator-configuration definitions: channel indices, default constants
// and the commit state encoding used by the parameter bank.
package sim_cfg_pkg;

  typedef logic [15:0] param_t;

  localparam int unsigned PARAM_TARGET_DENSITY = 0;
  localparam int unsigned PARAM_PRESSURE       = 1;
  localparam int unsigned PARAM_GRAVITY        = 2;
  localparam int unsigned PARAM_PARTICLE_COUNT = 3;

  localparam param_t DEF_TARGET_DENSITY = 16'd20;
  localparam param_t DEF_PRESSURE       = 16'hCA00;
  localparam param_t DEF_GRAVITY        = 16'h4800;
  localparam param_t DEF_PARTICLE_COUNT = 16'h4000;

  localparam logic [63:0] DEFAULT_BANK = {DEF_PARTICLE_COUNT, DEF_GRAVITY,
                                          DEF_PRESSURE, DEF_TARGET_DENSITY};

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } commit_state_t;

endpackage

// File: rtl/sim_param_bank_sat_step.sv
// Combinational saturating step (+/- STEP) on one WIDTH-bit unsigned value,
// with a flag telling whether the result differs from the input.
module sat_step #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] x,
  input  logic             up,
  output logic [WIDTH-1:0] y,
  output logic             changed
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MAX_EXT  = {1'b0, {WIDTH{1'b1}}};

  logic [WIDTH:0] x_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    x_ext = {1'b0, x};
    sum   = x_ext + STEP_EXT;
    diff  = x_ext - STEP_EXT;
    y     = x;
    if (up) begin
      y = (sum > MAX_EXT) ? '1 : sum[WIDTH-1:0];
    end else begin
      y = (x_ext < STEP_EXT) ? '0 : diff[WIDTH-1:0];
    end
    changed = (y != x);
  end

endmodule

// File: rtl/sim_param_bank.sv
// Bank of runtime simulation constants: edits land in a staged copy which is
// copied to the active copy at a frame-boundary commit (or automatically).
module sim_param_bank
  import sim_cfg_pkg::*;
#(
  parameter int unsigned NUM_PARAMS = 4,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned SEL_W      = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1,
  parameter logic [NUM_PARAMS*WIDTH-1:0] DEFAULTS = DEFAULT_BANK,
  parameter int unsigned STEP       = 1,
  parameter bit          COMMIT_ON_FRAME = 1'b1
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [SEL_W-1:0]            sel_in,
  input  logic [WIDTH-1:0]            value_in,
  input  logic                        load_in,
  input  logic                        step_up_in,
  input  logic                        step_down_in,
  input  logic                        restore_in,
  input  logic                        commit_in,
  output logic [NUM_PARAMS*WIDTH-1:0] params_out,
  output logic [WIDTH-1:0]            display_out,
  output logic                        dirty_out,
  output logic                        commit_pulse_out,
  output logic                        sel_err_out
);

  commit_state_t state, state_nxt;

  logic [NUM_PARAMS*WIDTH-1:0] staged_flat;
  logic [NUM_PARAMS-1:0]       wr_sel;
  logic [WIDTH-1:0]            wr_data;
  logic [WIDTH-1:0]            cur_val;
  logic [WIDTH-1:0]            step_val;
  logic                        step_changed;
  logic                        sel_ok;
  logic                        restore_diff;
  logic                        effective;
  logic                        sel_fault;
  logic                        commit_go;

  assign sel_ok = (32'(sel_in) < NUM_PARAMS);

  // Out-of-range selects match no channel, so cur_val falls back to zero.
  always_comb begin
    cur_val      = '0;
    restore_diff = 1'b0;
    for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
      if (32'(sel_in) == i) cur_val = staged_flat[i*WIDTH +: WIDTH];
      if (staged_flat[i*WIDTH +: WIDTH] != DEFAULTS[i*WIDTH +: WIDTH]) restore_diff = 1'b1;
    end
  end

  sat_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_sat_step (
    .x       (cur_val),
    .up      (step_up_in),
    .y       (step_val),
    .changed (step_changed)
  );

  always_comb begin
    wr_sel    = '0;
    wr_data   = value_in;
    effective = 1'b0;
    sel_fault = 1'b0;
    if (restore_in) begin
      effective = restore_diff;
    end else if (load_in || step_up_in || step_down_in) begin
      if (!sel_ok) begin
        sel_fault = 1'b1;
      end else begin
        if (load_in) begin
          effective = (value_in != cur_val);
        end else begin
          wr_data   = step_val;
          effective = step_changed;
        end
        for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
          wr_sel[i] = (32'(sel_in) == i);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_bank
    logic [WIDTH-1:0] staged;
    logic [WIDTH-1:0] active;

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        staged <= DEFAULTS[g*WIDTH +: WIDTH];
        active <= DEFAULTS[g*WIDTH +: WIDTH];
      end else begin
        if (restore_in)     staged <= DEFAULTS[g*WIDTH +: WIDTH];
        else if (wr_sel[g]) staged <= wr_data;
        // Commit copies the pre-edit staged value; a same-cycle edit waits.
        if (commit_go)      active <= staged;
      end
    end

    assign staged_flat[g*WIDTH +: WIDTH] = staged;
    assign params_out[g*WIDTH +: WIDTH]  = active;
  end

  always_comb begin
    state_nxt = state;
    commit_go = COMMIT_ON_FRAME ? ((state == ST_PENDING) && commit_in)
                                : (state == ST_PENDING);
    case (state)
      ST_IDLE:    if (effective) state_nxt = ST_PENDING;
      ST_PENDING: if (commit_go && !effective) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= ST_IDLE;
      commit_pulse_out <= 1'b0;
      sel_err_out      <= 1'b0;
      display_out      <= DEFAULTS[WIDTH-1:0];
    end else begin
      state            <= state_nxt;
      commit_pulse_out <= commit_go;
      if (sel_fault) sel_err_out <= 1'b1;
      display_out      <= cur_val;
    end
  end

  assign dirty_out = (state == ST_PENDING);

endmodule
